i2s_playback_tx: RTL

- Playback serializer in the CODEC bit-clock domain, directly downstream of the playback audio FIFO.
- Pops one 64-bit stereo frame per LR period from an AXI4-Stream slave and shifts it MSB-first onto ac_pbdat in I2S format.
- Timing follows ac_bclk and ac_pblrc, both supplied by the CODEC in master mode.
- Handles start-up alignment, runtime word-length selection and FIFO underrun.

---
 rtl/audio_i2s_pkg.sv | 24 ++
 rtl/i2s_playback_tx_if.sv | 11 +
 rtl/i2s_lrclk_edge_detect.sv | 31 +++
 rtl/i2s_playback_tx.sv | 106 ++++++++++
 4 files changed

// File: rtl/audio_i2s_pkg.sv
// rtl/audio_i2s_pkg.sv - shared I2S word-length types and lane layout constants
package audio_i2s_pkg;

  localparam int SLOT_BITS      = 32;
  localparam int LEFT_LANE_MSB  = 63;
  localparam int RIGHT_LANE_MSB = 31;

  typedef enum logic [1:0] {
    WL_16 = 2'b00,
    WL_20 = 2'b01,
    WL_24 = 2'b10,
    WL_32 = 2'b11
  } wl_e;

  function automatic logic [5:0] wl_bits(input wl_e wl);
    case (wl)
      WL_16:   return 6'd16;
      WL_20:   return 6'd20;
      WL_24:   return 6'd24;
      default: return 6'd32;
    endcase
  endfunction

endpackage

// File: rtl/i2s_playback_tx_if.sv
// rtl/i2s_playback_tx_if.sv - stereo frame stream from the playback FIFO (64-bit frames)
interface i2s_playback_tx_if;

  logic        tvalid;
  logic        tready;
  logic [63:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);

endinterface

// File: rtl/i2s_lrclk_edge_detect.sv
// rtl/i2s_lrclk_edge_detect.sv - LR clock edge detect and first-left-slot alignment
// Shared by the playback serializer and the record-path deserializer.
module i2s_lrclk_edge_detect (
  input  logic ac_bclk,
  input  logic axis_aresetn,
  input  logic lrc,
  output logic lstart,
  output logic rstart,
  output logic active,
  output logic active_next
);

  logic lrc_q;

  always_ff @(posedge ac_bclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      lrc_q  <= 1'b0;
      active <= 1'b0;
    end else begin
      lrc_q  <= lrc;
      active <= active_next;
    end
  end

  // lrc_q leaves reset at 0, so a high lrc at release only looks like an
  // rstart, which is discarded until alignment.
  assign lstart      = lrc_q & ~lrc;
  assign rstart      = ~lrc_q & lrc;
  assign active_next = active | lstart;

endmodule

// File: rtl/i2s_playback_tx.sv
// rtl/i2s_playback_tx.sv - I2S playback serializer, one stereo frame per LR period
// Optional underrun_count output under `define I2S_PLAYBACK_UNDERRUN_COUNT_EN.
module i2s_playback_tx #(
  parameter int UNDERRUN_HOLD = 0,
  parameter int SLOT_BITS     = 32
) (
  input  logic               ac_bclk,
  input  logic               axis_aresetn,
  input  logic               ac_pblrc,
  output logic               ac_pbdat,
  input  logic [1:0]         word_length,
  i2s_playback_tx_if.slave   s_axis,
  output logic               underrun,
  output logic               active
`ifdef I2S_PLAYBACK_UNDERRUN_COUNT_EN
  ,
  output logic [15:0]        underrun_count
`endif
);

  import audio_i2s_pkg::*;

  localparam logic [4:0] CNT_MAX = 5'(SLOT_BITS - 1);

  logic        lstart;
  logic        rstart;
  logic        active_next;
  logic        fetch;
  logic        rload;
  logic [31:0] shifter;
  logic [31:0] hold_l;
  logic [31:0] hold_r;
  wl_e         wl_q;
  logic [4:0]  cnt;
  logic [5:0]  wl_n;
  logic [4:0]  bit_idx;
  logic        tx_bit;

  i2s_lrclk_edge_detect u_edge (
    .ac_bclk      (ac_bclk),
    .axis_aresetn (axis_aresetn),
    .lrc          (ac_pblrc),
    .lstart       (lstart),
    .rstart       (rstart),
    .active       (active),
    .active_next  (active_next)
  );

  assign s_axis.tready = lstart & active_next;
  assign fetch         = s_axis.tready & s_axis.tvalid;
  assign underrun      = s_axis.tready & ~s_axis.tvalid;
  assign rload         = rstart & active;

  always_ff @(posedge ac_bclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      shifter <= '0;
      hold_l  <= '0;
      hold_r  <= '0;
      wl_q    <= WL_16;
      cnt     <= '0;
    end else if (lstart) begin
      cnt <= '0;
      if (fetch) begin
        shifter <= s_axis.tdata[LEFT_LANE_MSB:RIGHT_LANE_MSB+1];
        hold_l  <= s_axis.tdata[LEFT_LANE_MSB:RIGHT_LANE_MSB+1];
        hold_r  <= s_axis.tdata[RIGHT_LANE_MSB:0];
        wl_q    <= wl_e'(word_length);
      end else if (UNDERRUN_HOLD != 0) begin
        shifter <= hold_l;
      end else begin
        shifter <= '0;
        hold_r  <= '0;
      end
    end else if (rload) begin
      cnt     <= '0;
      shifter <= hold_r;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 5'd1;
    end
  end

  // Samples are right-justified in the lane, so the MSB sits at WL-1.
  assign wl_n    = wl_bits(wl_q);
  assign bit_idx = 5'(wl_n - 6'd1 - {1'b0, cnt});
  assign tx_bit  = active && ({1'b0, cnt} < wl_n) && shifter[bit_idx];

  // Falling-edge retime gives the one-bclk I2S delay after the LR edge.
  always_ff @(negedge ac_bclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      ac_pbdat <= 1'b0;
    end else begin
      ac_pbdat <= tx_bit;
    end
  end

`ifdef I2S_PLAYBACK_UNDERRUN_COUNT_EN
  always_ff @(posedge ac_bclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      underrun_count <= '0;
    end else if (underrun && underrun_count != 16'hFFFF) begin
      underrun_count <= underrun_count + 16'd1;
    end
  end
`endif

endmodule
